dma_bus_arbiter: RTL and testbench

- Shares the external address/data bus between the CPU core and a block-copy DMA engine.
- On a start pulse it holds the core via its ready input. Because the core only freezes on read cycles, the block waits for a core read cycle before taking the bus.
- It then performs LEN read/write byte pairs from a source region to a destination region, and returns the bus.
- Sits between the core's bus outputs and the memory/peripheral fabric.

---
 rtl/dma_pkg.sv | 20 ++
 rtl/dma_transfer_counter.sv | 48 ++++
 rtl/dma_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_dma_bus_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and defaults for the DMA bus arbiter and its transfer counter.
package dma_pkg;

    typedef enum logic [2:0] {
        IDLE,
        STALL,
        READ,
        WRITE,
        RELEASE
    } dma_state_e;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_LEN_W  = 8;

    // A programmed length of zero encodes the full 2^len_w byte range.
    function automatic logic [31:0] effective_len(input logic [31:0] len, input int len_w);
        return (len == 32'd0) ? (32'd1 << len_w) : len;
    endfunction

endpackage

// File: rtl/dma_transfer_counter.sv
// Byte index and remaining-count tracker for one block copy.
module dma_transfer_counter
    import dma_pkg::*;
#(
    parameter int LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [LEN_W-1:0] len,
    output logic [LEN_W-1:0] idx,
    output logic             last
);

    localparam int REM_W = LEN_W + 1;

    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REM_W-1:0] rem_q, rem_d;

    // NOTE: every always_comb output is given a default first, so no path can infer a latch.
    always_comb begin
        idx_d = idx_q;
        rem_d = rem_q;
        if (load) begin
            idx_d = '0;
            rem_d = REM_W'(effective_len(32'(len), LEN_W));
        end else if (dec) begin
            idx_d = idx_q + LEN_W'(1);
            rem_d = rem_q - REM_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            rem_q <= '0;
        end else begin
            idx_q <= idx_d;
            rem_q <= rem_d;
        end
    end

    assign idx  = idx_q;
    assign last = (rem_q == REM_W'(1));

endmodule

// File: rtl/dma_bus_arbiter.sv
// Shares the external bus between the CPU core and a block-copy DMA engine;
// the core is held via ready and the bus is taken only once the core is frozen on a read.
module dma_bus_arbiter
    import dma_pkg::*;
#(
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int LEN_W          = DEFAULT_LEN_W,
    parameter int HANDOFF_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpuAddress,
    input  logic [7:0]        cpuDataOut,
    input  logic              cpuReadNotWrite,
    output logic              cpuReady,
    output logic [ADDR_W-1:0] busAddress,
    output logic [7:0]        busDataOut,
    output logic              busReadNotWrite,
    input  logic [7:0]        busDataIn,
    input  logic              dmaStart,
    input  logic [ADDR_W-1:0] dmaSrc,
    input  logic [ADDR_W-1:0] dmaDst,
    input  logic [LEN_W-1:0]  dmaLen,
    output logic              dmaBusy,
    output logic              dmaDone
);

    localparam int              HO_W    = (HANDOFF_CYCLES > 1) ? $clog2(HANDOFF_CYCLES) : 1;
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(HANDOFF_CYCLES - 1);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [7:0]        data_q, data_d;
    logic [HO_W-1:0]   ho_q, ho_d;
    logic              done_q, done_d;

    logic              cnt_load;
    logic              cnt_dec;
    logic              cnt_last;
    logic [LEN_W-1:0]  cnt_idx;
    logic [ADDR_W-1:0] idx_ext;

    assign idx_ext = ADDR_W'(cnt_idx);

    dma_transfer_counter #(
        .LEN_W (LEN_W)
    ) u_counter (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .dec  (cnt_dec),
        .len  (dmaLen),
        .idx  (cnt_idx),
        .last (cnt_last)
    );

    always_comb begin
        state_d         = state_q;
        src_d           = src_q;
        dst_d           = dst_q;
        data_d          = data_q;
        ho_d            = ho_q;
        done_d          = 1'b0;
        cnt_load        = 1'b0;
        cnt_dec         = 1'b0;
        cpuReady        = 1'b0;
        busAddress      = cpuAddress;
        busDataOut      = cpuDataOut;
        busReadNotWrite = cpuReadNotWrite;

        case (state_q)
            IDLE: begin
                cpuReady = 1'b1;
                if (dmaStart) begin
                    src_d    = dmaSrc;
                    dst_d    = dmaDst;
                    cnt_load = 1'b1;
                    state_d  = STALL;
                end
            end
            // Core writes still complete here; only a read cycle actually freezes the core.
            STALL: begin
                if (cpuReadNotWrite) begin
                    state_d = READ;
                end
            end
            READ: begin
                busAddress      = src_q + idx_ext;
                busReadNotWrite = 1'b1;
                data_d          = busDataIn;
                state_d         = WRITE;
            end
            WRITE: begin
                busAddress      = dst_q + idx_ext;
                busReadNotWrite = 1'b0;
                busDataOut      = data_q;
                cnt_dec         = 1'b1;
                if (cnt_last) begin
                    ho_d    = HO_LOAD;
                    state_d = RELEASE;
                end else begin
                    state_d = READ;
                end
            end
            RELEASE: begin
                if (ho_q == '0) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    ho_d = ho_q - HO_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            data_q  <= '0;
            ho_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            data_q  <= data_d;
            ho_q    <= ho_d;
            done_q  <= done_d;
        end
    end

    assign dmaBusy = (state_q != IDLE);
    assign dmaDone = done_q;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed bench for dma_bus_arbiter: a transfer-timeline model checks every cycle,
// literal expectations pin memory contents, cycle counts and done pulses.
module tb_dma_bus_arbiter;

    localparam int ADDR_W  = 16;
    localparam int LEN_W   = 8;
    localparam int HANDOFF = 1;

    logic        clk             = 1'b0;
    logic        rst             = 1'b0;
    logic [15:0] cpuAddress      = 16'h8000;
    logic [7:0]  cpuDataOut      = 8'h00;
    logic        cpuReadNotWrite = 1'b1;
    logic        cpuReady;
    logic [15:0] busAddress;
    logic [7:0]  busDataOut;
    logic        busReadNotWrite;
    logic [7:0]  busDataIn;
    logic        dmaStart        = 1'b0;
    logic [15:0] dmaSrc          = 16'h0000;
    logic [15:0] dmaDst          = 16'h0000;
    logic [7:0]  dmaLen          = 8'h00;
    logic        dmaBusy;
    logic        dmaDone;

    dma_bus_arbiter #(
        .ADDR_W         (ADDR_W),
        .LEN_W          (LEN_W),
        .HANDOFF_CYCLES (HANDOFF)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cpuAddress      (cpuAddress),
        .cpuDataOut      (cpuDataOut),
        .cpuReadNotWrite (cpuReadNotWrite),
        .cpuReady        (cpuReady),
        .busAddress      (busAddress),
        .busDataOut      (busDataOut),
        .busReadNotWrite (busReadNotWrite),
        .busDataIn       (busDataIn),
        .dmaStart        (dmaStart),
        .dmaSrc          (dmaSrc),
        .dmaDst          (dmaDst),
        .dmaLen          (dmaLen),
        .dmaBusy         (dmaBusy),
        .dmaDone         (dmaDone)
    );

    always #5 clk = ~clk;

    // Fabric memory: unwritten locations read back an address-derived pattern.
    logic [7:0] mem [65536];
    bit         written [65536];

    function automatic logic [7:0] rd(input logic [15:0] a);
        return written[a] ? mem[a] : (a[7:0] ^ a[15:8] ^ 8'h5A);
    endfunction

    assign busDataIn = rd(busAddress);

    always @(posedge clk) begin
        if (!rst && !busReadNotWrite) begin
            mem[busAddress]     <= busDataOut;
            written[busAddress] <= 1'b1;
        end
    end

    int tests       = 0;
    int fails       = 0;
    int busy_cycles = 0;
    int done_pulses = 0;

    // Model: where the current cycle sits on the transfer timeline.
    bit          m_busy      = 1'b0;
    bit          m_done      = 1'b0;
    int          m_t         = 0;
    int          m_stall_end = -1;
    int          m_len       = 0;
    logic [15:0] m_src       = 16'h0000;
    logic [15:0] m_dst       = 16'h0000;
    logic [7:0]  m_buf       = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic        e_ready, e_rnw, e_busy, e_done, chk_data;
        logic [15:0] e_addr;
        logic [7:0]  e_data;
        int          j;
        e_ready  = 1'b1;
        e_busy   = 1'b0;
        e_done   = 1'b0;
        e_addr   = cpuAddress;
        e_rnw    = cpuReadNotWrite;
        e_data   = cpuDataOut;
        chk_data = 1'b1;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
        end else if (!m_busy) begin
            e_done = m_done;
            m_done = 1'b0;
            if (dmaStart) begin
                m_busy      = 1'b1;
                m_t         = 0;
                m_stall_end = -1;
                m_src       = dmaSrc;
                m_dst       = dmaDst;
                m_len       = (dmaLen == 8'd0) ? 256 : int'(dmaLen);
            end
        end else begin
            e_ready = 1'b0;
            e_busy  = 1'b1;
            if (m_stall_end < 0) begin
                if (cpuReadNotWrite) m_stall_end = m_t + 1;
            end else begin
                j = m_t - m_stall_end;
                if (j < 2 * m_len) begin
                    if (j % 2 == 0) begin
                        e_addr   = m_src + 16'(j / 2);
                        e_rnw    = 1'b1;
                        chk_data = 1'b0;
                        m_buf    = rd(e_addr);
                    end else begin
                        e_addr = m_dst + 16'(j / 2);
                        e_rnw  = 1'b0;
                        e_data = m_buf;
                    end
                end
                if (j == 2 * m_len + HANDOFF - 1) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end
            m_t++;
        end
        if (dmaBusy) busy_cycles++;
        if (dmaDone) done_pulses++;
        check("cyc_ready", 32'(cpuReady), 32'(e_ready));
        check("cyc_addr", 32'(busAddress), 32'(e_addr));
        check("cyc_rnw", 32'(busReadNotWrite), 32'(e_rnw));
        if (chk_data) check("cyc_wdata", 32'(busDataOut), 32'(e_data));
        check("cyc_busy", 32'(dmaBusy), 32'(e_busy));
        check("cyc_done", 32'(dmaDone), 32'(e_done));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic core_rd(input logic [15:0] a);
        cpuAddress      = a;
        cpuDataOut      = 8'h00;
        cpuReadNotWrite = 1'b1;
    endtask

    task automatic core_wr(input logic [15:0] a, input logic [7:0] d);
        cpuAddress      = a;
        cpuDataOut      = d;
        cpuReadNotWrite = 1'b0;
    endtask

    task automatic start_dma(input logic [15:0] s, input logic [15:0] d, input logic [7:0] l);
        dmaSrc   = s;
        dmaDst   = d;
        dmaLen   = l;
        dmaStart = 1'b1;
        tick();
        dmaStart = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (dmaBusy && n < budget) begin
            tick();
            n++;
        end
        check(name, 32'(dmaBusy), 32'd0);
    endtask

    int  b0, d0;
    bit  found;

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_ready", 32'(cpuReady), 32'd1);
        check("rst_busy", 32'(dmaBusy), 32'd0);
        check("rst_done", 32'(dmaDone), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Basic copy, with the source bytes written by the core through the bus.
        core_wr(16'h0200, 8'hAA); tick();
        core_wr(16'h0201, 8'hBB); tick();
        core_wr(16'h0202, 8'hCC); tick();
        core_rd(16'h8000);
        b0 = busy_cycles; d0 = done_pulses;
        start_dma(16'h0200, 16'h4000, 8'd3);
        wait_idle(40, "t1_finish");
        check("t1_done_on_idle", 32'(dmaDone), 32'd1);
        check("t1_ready_back", 32'(cpuReady), 32'd1);
        tick();
        check("t1_busy_cycles", 32'(busy_cycles - b0), 32'd8);
        check("t1_done_count", 32'(done_pulses - d0), 32'd1);
        check("t1_dst0", 32'(rd(16'h4000)), 32'hAA);
        check("t1_dst1", 32'(rd(16'h4001)), 32'hBB);
        check("t1_dst2", 32'(rd(16'h4002)), 32'hCC);

        // Start while the core performs three back-to-back writes.
        b0 = busy_cycles; d0 = done_pulses;
        core_wr(16'h0300, 8'h11);
        start_dma(16'h0200, 16'h4100, 8'd2);
        core_wr(16'h0301, 8'h22);
        #1;
        check("t2_ready_low_on_write", 32'(cpuReady), 32'd0);
        check("t2_write_passes", 32'(busAddress), 32'h0301);
        tick();
        core_wr(16'h0302, 8'h33); tick();
        core_rd(16'h8000);
        wait_idle(40, "t2_finish");
        tick();
        check("t2_busy_cycles", 32'(busy_cycles - b0), 32'd8);
        check("t2_done_count", 32'(done_pulses - d0), 32'd1);
        check("t2_core_w0", 32'(rd(16'h0300)), 32'h11);
        check("t2_core_w1", 32'(rd(16'h0301)), 32'h22);
        check("t2_core_w2", 32'(rd(16'h0302)), 32'h33);
        check("t2_dst0", 32'(rd(16'h4100)), 32'hAA);
        check("t2_dst1", 32'(rd(16'h4101)), 32'hBB);

        // Length zero means 256 bytes; the source wraps past 0xFFFF.
        b0 = busy_cycles; d0 = done_pulses;
        start_dma(16'hFF80, 16'h0100, 8'd0);
        wait_idle(600, "t3_finish");
        tick();
        check("t3_busy_cycles", 32'(busy_cycles - b0), 32'd514);
        check("t3_done_count", 32'(done_pulses - d0), 32'd1);
        check("t3_dst_first", 32'(rd(16'h0100)), 32'h25);
        check("t3_dst_wrapped", 32'(rd(16'h0180)), 32'h5A);
        check("t3_dst_last", 32'(rd(16'h01FF)), 32'h25);

        // A second start while busy is ignored.
        b0 = busy_cycles; d0 = done_pulses;
        start_dma(16'h0200, 16'h5000, 8'd3);
        tick();
        dmaSrc = 16'h0000; dmaDst = 16'h6000; dmaLen = 8'd1; dmaStart = 1'b1;
        tick();
        dmaStart = 1'b0;
        wait_idle(40, "t4_finish");
        tick();
        check("t4_busy_cycles", 32'(busy_cycles - b0), 32'd8);
        check("t4_done_count", 32'(done_pulses - d0), 32'd1);
        check("t4_dst0", 32'(rd(16'h5000)), 32'hAA);
        check("t4_dst2", 32'(rd(16'h5002)), 32'hCC);
        check("t4_second_untouched", 32'(rd(16'h6000)), 32'h3A);

        // Reset during the write of the second of five bytes.
        d0 = done_pulses;
        start_dma(16'h0210, 16'h7000, 8'd5);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (dmaBusy && !busReadNotWrite && busAddress == 16'h7001) found = 1'b1;
            else tick();
        end
        check("t5_reached_write", 32'(found), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("t5_rst_ready", 32'(cpuReady), 32'd1);
        check("t5_rst_busy", 32'(dmaBusy), 32'd0);
        check("t5_rst_done", 32'(dmaDone), 32'd0);
        check("t5_rst_addr", 32'(busAddress), 32'h8000);
        check("t5_rst_rnw", 32'(busReadNotWrite), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        check("t5_done_count", 32'(done_pulses - d0), 32'd0);
        check("t5_first_copied", 32'(rd(16'h7000)), 32'h48);
        check("t5_second_aborted", 32'(rd(16'h7001)), 32'h2B);
        check("t5_idle_after", 32'(dmaBusy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
